// File: rtl/ram_1p_bist_master.sv
// ============================================================================
//  Module   : ram_1p_bist_master
//  Brief    : Write/read-back self-test initiator for a single-port 32-bit RAM
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_1p_bist_master #(
   parameter int unsigned Depth    = 16384,
   parameter logic [31:0] BaseAddr = 32'h0000_0000,
   parameter int unsigned ErrW     = 16,
   localparam int unsigned Aw      = $clog2(Depth)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [Aw:0]     num_words_i,
   input  logic [31:0]     seed_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            pass_o,
   output logic [ErrW-1:0] err_count_o,
   output logic [31:0]     first_err_addr_o,
   output logic            req_o,
   output logic            we_o,
   output logic [3:0]      be_o,
   output logic [31:0]     addr_o,
   output logic [31:0]     wdata_o,
   input  logic            rvalid_i,
   input  logic [31:0]     rdata_i
);

   localparam int unsigned     c_idx_w   = Aw + 1;
   localparam logic [Aw:0]     c_depth   = c_idx_w'(Depth);
   localparam logic [ErrW-1:0] c_err_max = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t         r_state;
   logic [Aw:0]    r_n;
   logic [Aw:0]    r_idx;
   logic [31:0]    r_seed;
   logic           r_exp_valid;
   logic [31:0]    r_exp_data;
   logic [31:0]    r_exp_addr;

   logic [Aw:0]     w_n_clamp;
   logic            w_last;
   logic [Aw:0]     w_idx_nxt;
   logic [31:0]     w_addr_nxt;
   logic [31:0]     w_data_nxt;
   logic            w_mismatch;
   logic [ErrW-1:0] w_err_nxt;

   assign w_n_clamp  = (num_words_i > c_depth) ? c_depth : num_words_i;
   assign w_last     = (r_idx == (r_n - 1'b1));
   assign w_idx_nxt  = r_idx + 1'b1;
   assign w_addr_nxt = BaseAddr + (32'(w_idx_nxt) << 2);
   assign w_data_nxt = r_seed + 32'(w_idx_nxt);

   // A missing response counts as a mismatch just like wrong data.
   assign w_mismatch = r_exp_valid && (!rvalid_i || (rdata_i != r_exp_data));
   assign w_err_nxt  = (w_mismatch && (err_count_o != c_err_max)) ?
                       err_count_o + 1'b1 : err_count_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state          <= S_IDLE;
         r_n              <= '0;
         r_idx            <= '0;
         r_seed           <= '0;
         r_exp_valid      <= 1'b0;
         r_exp_data       <= '0;
         r_exp_addr       <= '0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         pass_o           <= 1'b0;
         err_count_o      <= '0;
         first_err_addr_o <= '0;
         req_o            <= 1'b0;
         we_o             <= 1'b0;
         be_o             <= 4'h0;
         addr_o           <= '0;
         wdata_o          <= '0;
      end else begin
         r_exp_valid <= 1'b0;
         done_o      <= 1'b0;

         if (w_mismatch) begin
            err_count_o <= w_err_nxt;
            if (err_count_o == '0) begin
               first_err_addr_o <= r_exp_addr;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_n              <= w_n_clamp;
                  r_seed           <= seed_i;
                  r_idx            <= '0;
                  err_count_o      <= '0;
                  first_err_addr_o <= '0;
                  pass_o           <= 1'b0;
                  busy_o           <= 1'b1;
                  // An empty run still spends one cycle in DRAIN so the
                  // done pulse lands at the same 2n+2 offset as any other run.
                  if (w_n_clamp == '0) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_state <= S_WRITE;
                     req_o   <= 1'b1;
                     we_o    <= 1'b1;
                     be_o    <= 4'hF;
                     addr_o  <= BaseAddr;
                     wdata_o <= seed_i;
                  end
               end
            end

            S_WRITE: begin
               if (w_last) begin
                  r_idx   <= '0;
                  r_state <= S_READ;
                  we_o    <= 1'b0;
                  addr_o  <= BaseAddr;
                  wdata_o <= '0;
               end else begin
                  r_idx   <= w_idx_nxt;
                  addr_o  <= w_addr_nxt;
                  wdata_o <= w_data_nxt;
               end
            end

            S_READ: begin
               // Expectation for the request now on the bus; its response
               // arrives in the following cycle.
               r_exp_valid <= 1'b1;
               r_exp_data  <= r_seed + 32'(r_idx);
               r_exp_addr  <= addr_o;
               if (w_last) begin
                  r_state <= S_DRAIN;
                  req_o   <= 1'b0;
                  be_o    <= 4'h0;
                  addr_o  <= '0;
               end else begin
                  r_idx  <= w_idx_nxt;
                  addr_o <= w_addr_nxt;
               end
            end

            S_DRAIN: begin
               r_state <= S_DONE;
               busy_o  <= 1'b0;
               done_o  <= 1'b1;
               pass_o  <= (w_err_nxt == '0);
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
